shift_add_mult: RTL and testbench

//  Parametrised sequential shift-add multiplier. Multiplies two WIDTH-bit operands, signed or unsigned per request.

---
 rtl/shift_add_mult.sv | 105 ++++++++++
 tb/tb_shift_add_mult.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/shift_add_mult.sv
// Sequential shift-add multiplier with a start/done handshake and runtime signed/unsigned mode.
// Define MULT_EARLY_TERM_EN to leave CALC as soon as the remaining multiplier bits are all zero.
module shift_add_mult #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] out
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [CNT_W-1:0]   cnt;
    logic               neg;
    logic [2*WIDTH-1:0] mcandWide;
    logic               calcDone;

    assign mcandWide = {{WIDTH{1'b0}}, mcand};

    // The extra CALC edge that recognises completion keeps the fixed-latency and early-terminating builds aligned.
`ifdef MULT_EARLY_TERM_EN
    assign calcDone = (mplier == '0);
`else
    assign calcDone = (cnt == CNT_W'(WIDTH));
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            out    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        // Multiply magnitudes; the most negative operand's magnitude still fits in WIDTH unsigned bits.
                        if (signed_mode) begin
                            mcand  <= A[WIDTH-1] ? -A : A;
                            mplier <= B[WIDTH-1] ? -B : B;
                            neg    <= A[WIDTH-1] ^ B[WIDTH-1];
                        end else begin
                            mcand  <= A;
                            mplier <= B;
                            neg    <= 1'b0;
                        end
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    if (calcDone) begin
                        state <= FIX;
                    end else begin
                        if (mplier[0]) begin
                            acc <= acc + (mcandWide << cnt);
                        end
                        mplier <= mplier >> 1;
                        cnt    <= cnt + CNT_W'(1);
                    end
                end
                FIX: begin
                    out   <= neg ? -acc : acc;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    if (!start) begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_mult.sv
// Randomised and directed checks of shift_add_mult (WIDTH=8) against an arithmetic product and latency model.
module tb_shift_add_mult;

    localparam int W = 8;

    logic           clk;
    logic           reset;
    logic           start;
    logic           signed_mode;
    logic [W-1:0]   A;
    logic [W-1:0]   B;
    logic           busy;
    logic           done;
    logic [2*W-1:0] out;

    int errors = 0;
    int checks = 0;
    logic [2*W-1:0] prevOut;

    shift_add_mult #(.WIDTH(W)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .signed_mode(signed_mode),
        .A(A),
        .B(B),
        .busy(busy),
        .done(done),
        .out(out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [2*W-1:0] refProduct(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm);
        int sa;
        int sb;
        int p;
        if (sm) begin
            sa = int'($signed(a));
            sb = int'($signed(b));
        end else begin
            sa = int'(a);
            sb = int'(b);
        end
        p = sa * sb;
        return p[2*W-1:0];
    endfunction

    function automatic int refLatency(input logic [W-1:0] b, input logic sm);
        int mag;
        int top;
        mag = (sm && b[W-1]) ? (1 << W) - int'(b) : int'(b);
        top = -1;
        for (int i = 0; i < W; i++) begin
            if (mag[i]) top = i;
        end
`ifdef MULT_EARLY_TERM_EN
        return 2 + top + 1;
`else
        return W + 2;
`endif
    endfunction

    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm, input int holdExtra);
        logic [2*W-1:0] expOut;
        int expLat;
        int edges;
        expOut = refProduct(a, b, sm);
        expLat = refLatency(b, sm);
        @(negedge clk);
        A = a;
        B = b;
        signed_mode = sm;
        start = 1'b1;
        @(posedge clk);
        #1;
        edges = 0;
        checkOutput("busy_after_capture", 32'(busy), 32'd1);
        while (!done && edges < 100) begin
            A = W'($urandom);
            B = W'($urandom);
            signed_mode = 1'($urandom);
            if (busy) checkOutput("out_stable_while_busy", 32'(out), 32'(prevOut));
            @(posedge clk);
            #1;
            edges++;
        end
        checkOutput("done_seen", 32'(done), 32'd1);
        checkOutput("latency", 32'(edges), 32'(expLat));
        checkOutput("product", 32'(out), 32'(expOut));
        checkOutput("busy_in_done", 32'(busy), 32'd0);
        for (int i = 0; i < holdExtra; i++) begin
            @(posedge clk);
            #1;
            checkOutput("done_held", 32'(done), 32'd1);
            checkOutput("out_held", 32'(out), 32'(expOut));
        end
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("done_dropped", 32'(done), 32'd0);
        checkOutput("out_kept_in_idle", 32'(out), 32'(expOut));
        prevOut = expOut;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        signed_mode = 1'b0;
        A = '0;
        B = '0;
        prevOut = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_out", 32'(out), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        applyStimulus(8'h80, 8'hFF, 1'b0, 0);
        applyStimulus(8'h80, 8'hFF, 1'b1, 0);
        applyStimulus(8'h80, 8'h80, 1'b1, 0);
        applyStimulus(8'h7F, 8'h81, 1'b1, 0);
        applyStimulus(8'h7F, 8'h7F, 1'b0, 5);
        applyStimulus(8'h12, 8'h00, 1'b0, 0);
        applyStimulus(8'h5A, 8'h01, 1'b1, 0);
        applyStimulus(8'hFF, 8'hFF, 1'b0, 0);

        @(negedge clk);
        A = 8'd9;
        B = 8'd11;
        signed_mode = 1'b0;
        start = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("midcalc_reset_out", 32'(out), 32'd0);
        checkOutput("midcalc_reset_done", 32'(done), 32'd0);
        checkOutput("midcalc_reset_busy", 32'(busy), 32'd0);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        prevOut = '0;
        applyStimulus(8'd3, 8'd5, 1'b0, 0);

        for (int n = 0; n < 16; n++) begin
            applyStimulus(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
